// File: rtl/shadow_return_stack.sv
// Shadow return-address stack: checks every RET/RETI target against pushed CALL/IRQ returns.
// Optional macro SRS_IRQ_TRACK_EN adds IRQ push/RETI checking with a per-entry tag bit.
module shadow_return_stack #(
  parameter int          DEPTH      = 8,
  parameter int          PTR_W      = 3,
  parameter logic [3:0]  CALL_STATE = 4'hB,
  parameter logic [3:0]  IRQ_STATE  = 4'h1,
  parameter logic [7:0]  CALL_INST  = 8'h20,
  parameter logic [7:0]  IRQ_INST   = 8'h80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       inst_so,
  input  logic [3:0]       e_state,
  input  logic [15:0]      ret_addr,
  input  logic             ret_valid,
  input  logic             ret_is_irq,
  input  logic [15:0]      ret_target,
  output logic [PTR_W:0]   sp_depth,
  output logic             violation,
  output logic [1:0]       viol_cause,
  output logic [15:0]      viol_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [15:0]     stack_q [DEPTH];
  logic [PTR_W:0]  sp_d;
  logic [PTR_W-1:0] top_idx;
  logic            call_cap, irq_cap, cap, pop, push;
  logic            full, empty, we;
  logic            ovf, udf, mis, any_viol;
  logic            tag_bad_bp, tag_bad_top;
  logic [1:0]      cause_d;
  logic [15:0]     vaddr_d;

  assign call_cap = (e_state == CALL_STATE) && (inst_so == CALL_INST);
  assign irq_cap  = (e_state == IRQ_STATE) && (inst_so == IRQ_INST);

`ifdef SRS_IRQ_TRACK_EN
  logic tag_q [DEPTH];
  logic push_irq_q;

  assign cap         = call_cap | irq_cap;
  assign pop         = ret_valid;
  assign tag_bad_bp  = push_irq_q != ret_is_irq;
  assign tag_bad_top = tag_q[top_idx] != ret_is_irq;

  always_ff @(posedge clk) begin
    if (rst) push_irq_q <= 1'b0;
    else     push_irq_q <= irq_cap;
  end

  always_ff @(posedge clk) begin
    if (we) tag_q[sp_depth[PTR_W-1:0]] <= push_irq_q;
  end
`else
  logic unused_irq;

  assign unused_irq  = irq_cap;
  assign cap         = call_cap;
  assign pop         = ret_valid & ~ret_is_irq;
  assign tag_bad_bp  = 1'b0;
  assign tag_bad_top = 1'b0;
`endif

  assign push    = state_q == PUSH;
  assign full    = sp_depth == FULL;
  assign empty   = sp_depth == '0;
  assign top_idx = sp_depth[PTR_W-1:0] - PTR_W'(1);
  assign we      = !rst && push && !pop && !full;

  assign violation = state_q == FAULT;

  always_comb begin
    ovf = 1'b0;
    udf = 1'b0;
    mis = 1'b0;
    if (state_q != FAULT) begin
      ovf = push && full;
      udf = pop && !push && empty;
      // a push landing with a return is logically first
      if (pop && push)
        mis = (ret_target != ret_addr) || tag_bad_bp;
      else if (pop && !empty)
        mis = (stack_q[top_idx] != ret_target) || tag_bad_top;
    end
  end

  assign any_viol = ovf | udf | mis;

  always_comb begin
    cause_d = 2'b01;
    vaddr_d = ret_target;
    if (ovf) begin
      cause_d = 2'b10;
      vaddr_d = ret_addr;
    end else if (udf) begin
      cause_d = 2'b11;
    end
  end

  always_comb begin
    state_d = state_q;
    sp_d    = sp_depth;
    if (state_q != FAULT) begin
      if (any_viol)  state_d = FAULT;
      else if (cap)  state_d = PUSH;
      else           state_d = IDLE;
      if (push && pop)
        sp_d = sp_depth;
      else if (push && !full)
        sp_d = sp_depth + (PTR_W+1)'(1);
      else if (pop && !empty)
        sp_d = sp_depth - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sp_depth   <= '0;
      viol_cause <= 2'b00;
      viol_addr  <= 16'h0000;
    end else if (state_q != FAULT) begin
      state_q  <= state_d;
      sp_depth <= sp_d;
      if (any_viol) begin
        viol_cause <= cause_d;
        viol_addr  <= vaddr_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) stack_q[sp_depth[PTR_W-1:0]] <= ret_addr;
  end

endmodule

// File: tb/tb_shadow_return_stack.sv
// Bench for shadow_return_stack: queue-based reference model plus directed literal checks.
// Honours SRS_IRQ_TRACK_EN in the model when the macro is defined.
module tb_shadow_return_stack;

  localparam int DEPTH = 8;

`ifdef SRS_IRQ_TRACK_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  inst_so;
  logic [3:0]  e_state;
  logic [15:0] ret_addr;
  logic        ret_valid;
  logic        ret_is_irq;
  logic [15:0] ret_target;
  logic [3:0]  sp_depth;
  logic        violation;
  logic [1:0]  viol_cause;
  logic [15:0] viol_addr;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [16:0] m_stk[$];
  bit          m_fault;
  logic [1:0]  m_cause;
  logic [15:0] m_addr;
  bit          m_pend;
  bit          m_pend_irq;

  shadow_return_stack dut (
    .clk        (clk),
    .rst        (rst),
    .inst_so    (inst_so),
    .e_state    (e_state),
    .ret_addr   (ret_addr),
    .ret_valid  (ret_valid),
    .ret_is_irq (ret_is_irq),
    .ret_target (ret_target),
    .sp_depth   (sp_depth),
    .violation  (violation),
    .viol_cause (viol_cause),
    .viol_addr  (viol_addr)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit is_call();
    return e_state == 4'hB && inst_so == 8'h20;
  endfunction

  function automatic bit is_irq();
    return IRQ_EN && e_state == 4'h1 && inst_so == 8'h80;
  endfunction

  // one clock of the specification's rules applied to the stack queue
  task automatic model_step();
    bit pop, ovf, udf, mis;
    logic [16:0] want;
    pop  = ret_valid && (IRQ_EN || !ret_is_irq);
    want = {IRQ_EN ? ret_is_irq : 1'b0, ret_target};
    if (rst) begin
      m_stk.delete();
      m_fault = 0; m_cause = 2'b00; m_addr = 16'h0;
      m_pend = 0; m_pend_irq = 0;
      return;
    end
    if (m_fault) return;
    ovf = m_pend && m_stk.size() == DEPTH;
    udf = pop && !m_pend && m_stk.size() == 0;
    mis = 0;
    if (pop && m_pend)
      mis = want != {m_pend_irq, ret_addr};
    else if (pop && m_stk.size() > 0)
      mis = want != m_stk[$];
    if (ovf) begin
      m_fault = 1; m_cause = 2'b10; m_addr = ret_addr;
    end else if (udf) begin
      m_fault = 1; m_cause = 2'b11; m_addr = ret_target;
    end else if (mis) begin
      m_fault = 1; m_cause = 2'b01; m_addr = ret_target;
    end
    if (m_pend && pop) ;
    else if (m_pend && m_stk.size() < DEPTH) m_stk.push_back({m_pend_irq, ret_addr});
    else if (pop && m_stk.size() > 0) void'(m_stk.pop_back());
    m_pend_irq = is_irq();
    m_pend = !m_fault && (is_call() || is_irq());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("sp_depth", 32'(sp_depth), 32'(m_stk.size()));
    check("violation", 32'(violation), 32'(m_fault));
    check("viol_cause", 32'(viol_cause), 32'(m_cause));
    check("viol_addr", 32'(viol_addr), 32'(m_addr));
  endtask

  task automatic idle();
    rst = 0; inst_so = 8'h00; e_state = 4'h0;
    ret_valid = 0; ret_is_irq = 0; ret_target = 16'h0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); idle(); tick();
  endtask

  task automatic do_cap(bit irq, logic [15:0] a);
    idle();
    e_state = irq ? 4'h1 : 4'hB;
    inst_so = irq ? 8'h80 : 8'h20;
    tick();
    idle(); ret_addr = a; tick();
  endtask

  task automatic do_ret(bit irq, logic [15:0] t);
    idle(); ret_valid = 1; ret_is_irq = irq; ret_target = t; tick();
    idle(); tick();
  endtask

  initial begin
    idle();
    ret_addr = 16'h0;
    rst = 1; tick(); tick();
    check("rst_sp", 32'(sp_depth), 32'd0);
    check("rst_viol", 32'(violation), 32'd0);
    check("rst_cause", 32'(viol_cause), 32'd0);
    check("rst_addr", 32'(viol_addr), 32'd0);

    do_reset();
    do_cap(0, 16'hC010);
    check("call_sp1", 32'(sp_depth), 32'd1);
    do_ret(0, 16'hC010);
    check("ret_sp0", 32'(sp_depth), 32'd0);
    check("ret_clean", 32'(violation), 32'd0);

    do_cap(0, 16'hC020);
    do_ret(0, 16'hC024);
    check("mis_viol", 32'(violation), 32'd1);
    check("mis_cause", 32'(viol_cause), 32'd1);
    check("mis_addr", 32'(viol_addr), 32'hC024);
    do_cap(0, 16'h1234);
    do_ret(0, 16'h5678);
    check("frozen_sp", 32'(sp_depth), 32'd0);
    check("frozen_addr", 32'(viol_addr), 32'hC024);

    do_reset();
    do_ret(0, 16'hE000);
    check("udf_cause", 32'(viol_cause), 32'd3);
    check("udf_addr", 32'(viol_addr), 32'hE000);
    check("udf_sp", 32'(sp_depth), 32'd0);

    do_reset();
    for (int i = 0; i <= DEPTH; i++) do_cap(0, 16'h1000 + 16'(i));
    check("ovf_cause", 32'(viol_cause), 32'd2);
    check("ovf_addr", 32'(viol_addr), 32'h1008);
    check("ovf_sp", 32'(sp_depth), 32'd8);

    do_reset();
    for (int i = 0; i < 3; i++) do_cap(0, 16'h2000 + 16'(i));
    idle(); e_state = 4'hB; inst_so = 8'h20; tick();
    idle(); ret_addr = 16'hA0A0; ret_valid = 1; ret_target = 16'hA0A0; tick();
    idle(); tick();
    check("byp_sp", 32'(sp_depth), 32'd3);
    check("byp_viol", 32'(violation), 32'd0);

`ifdef SRS_IRQ_TRACK_EN
    do_reset();
    do_cap(1, 16'hF100);
    do_ret(0, 16'hF100);
    check("irq_ret_cause", 32'(viol_cause), 32'd1);
    do_reset();
    do_cap(1, 16'hF100);
    do_ret(1, 16'hF100);
    check("irq_reti_viol", 32'(violation), 32'd0);
    check("irq_reti_sp", 32'(sp_depth), 32'd0);
`endif

    do_ret(0, 16'hBEEF);
    check("pre_rst_viol", 32'(violation), 32'd1);
    idle(); rst = 1; tick();
    check("fault_rst_viol", 32'(violation), 32'd0);
    check("fault_rst_cause", 32'(viol_cause), 32'd0);
    check("fault_rst_addr", 32'(viol_addr), 32'd0);
    check("fault_rst_sp", 32'(sp_depth), 32'd0);
    idle(); tick();

    for (int c = 0; c < 3000; c++) begin
      idle();
      ret_addr = 16'($urandom);
      if (m_fault && $urandom_range(0, 7) == 0) rst = 1;
      else if ($urandom_range(0, 199) == 0) rst = 1;
      case ($urandom_range(0, 5))
        0, 1: e_state = 4'hB;
        2:    e_state = 4'h1;
        default: e_state = 4'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0, 1: inst_so = 8'h20;
        2:    inst_so = 8'h80;
        default: inst_so = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) < 3) begin
        ret_valid  = 1;
        ret_is_irq = $urandom_range(0, 4) == 0;
        ret_target = 16'($urandom);
        if ($urandom_range(0, 3) != 0) begin
          if (m_pend) ret_target = ret_addr;
          else if (m_stk.size() > 0) ret_target = m_stk[$][15:0];
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
